// File: rtl/clyde_pkg.sv
// Shared constants, state encoding and helpers for the Clyde S-box layer sequencer.
package clyde_pkg;

   localparam int unsigned D        = 4;
   localparam int unsigned NCOLS    = 32;
   localparam int unsigned NPAR     = 4;
   localparam int unsigned NGRP     = NCOLS / NPAR;
   localparam int unsigned SBOX_LAT = 4;

   // Fresh random bits per masked AND gadget in one S-box (one bit per share pair)
   localparam int unsigned RND_W    = D * (D - 1) / 2;

   // Group index width, kept at least one bit so a single-group layer still has a port
   function automatic int unsigned grp_w(input int unsigned ngrp);
      return (ngrp > 1) ? int'($clog2(ngrp)) : 1;
   endfunction

   localparam int unsigned GW = grp_w(NGRP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/clyde_vld_pipe.sv
// Enable-gated valid/tag shift register mirroring the S-box pipeline depth.
module clyde_vld_pipe #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_vld,
   input  logic [TW-1:0] in_tag,
   output logic          out_vld,
   output logic [TW-1:0] out_tag
);

   logic [DEPTH-1:0] vld;
   logic [TW-1:0]    tag [DEPTH];

   // Advances only when the S-box bank advances, so tags stay aligned with data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < int'(DEPTH); i++) tag[i] <= '0;
      end else if (en) begin
         vld    <= {vld[DEPTH-2:0], in_vld};
         tag[0] <= in_tag;
         for (int i = 1; i < int'(DEPTH); i++) tag[i] <= tag[i-1];
      end
   end

   assign out_vld = vld[DEPTH-1];
   assign out_tag = tag[DEPTH-1];

endmodule

// File: rtl/clyde_sbox_layer_ctrl.sv
// Sequences one Clyde S-box layer through NPAR pipelined masked S-boxes.
// Optional stall counter port enabled by defining CLYDE_SBOX_STALL_CNT_EN.
module clyde_sbox_layer_ctrl
   import clyde_pkg::*;
#(
   parameter  int unsigned NCOLS = clyde_pkg::NCOLS,
   parameter  int unsigned NPAR  = clyde_pkg::NPAR,
   parameter  int unsigned LAT   = clyde_pkg::SBOX_LAT,
   localparam int unsigned NGRP  = NCOLS / NPAR,
   localparam int unsigned GW    = grp_w(NGRP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          rnd_valid,
   output logic          rnd_ready,
   output logic          sbox_en,
   output logic [GW-1:0] in_grp,
   output logic          in_vld,
   output logic [GW-1:0] out_grp,
   output logic          out_we
`ifdef CLYDE_SBOX_STALL_CNT_EN
  ,output logic [15:0]   stall_cnt
`endif
);

   state_t        state, state_nx;
   logic [GW-1:0] grp_q;
   logic [GW:0]   out_cnt;
   logic          last_in, last_out;
   logic          pipe_vld;
   logic [GW-1:0] pipe_tag;

   assign last_in  = (grp_q == GW'(NGRP - 1));
   assign last_out = out_we && (out_cnt == (GW+1)'(NGRP - 1));
   assign out_we   = pipe_vld & sbox_en;
   assign out_grp  = pipe_tag;
   assign in_grp   = grp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (start) state_nx = ST_FEED;
         ST_FEED:  if (sbox_en && last_in) state_nx = ST_DRAIN;
         ST_DRAIN: if (last_out) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Randomness is consumed on every enabled cycle, DRAIN included, as in-flight ANDs need it
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      in_vld    = 1'b0;
      sbox_en   = 1'b0;
      unique case (state)
         ST_FEED: begin
            busy    = 1'b1;
            in_vld  = 1'b1;
            sbox_en = rnd_valid;
         end
         ST_DRAIN: begin
            busy    = 1'b1;
            sbox_en = rnd_valid;
         end
         ST_DONE:  done = 1'b1;
         default: ;
      endcase
      rnd_ready = sbox_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_q   <= '0;
         out_cnt <= '0;
      end else if (state == ST_IDLE && start) begin
         grp_q   <= '0;
         out_cnt <= '0;
      end else begin
         if (state == ST_FEED && sbox_en && !last_in) grp_q <= grp_q + GW'(1);
         if (out_we) out_cnt <= out_cnt + (GW+1)'(1);
      end
   end

`ifdef CLYDE_SBOX_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       stall_cnt <= '0;
      else if (state == ST_IDLE && start)            stall_cnt <= '0;
      else if (busy && !rnd_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

   clyde_vld_pipe #(
      .DEPTH (LAT),
      .TW    (GW)
   ) u_vld_pipe (
      .clk     (clk),
      .rst     (rst),
      .en      (sbox_en),
      .in_vld  (in_vld),
      .in_tag  (grp_q),
      .out_vld (pipe_vld),
      .out_tag (pipe_tag)
   );

endmodule

// File: tb/tb_clyde_sbox_layer_ctrl.sv
// Scoreboard bench for clyde_sbox_layer_ctrl: default build (8 groups) and NPAR=32 (1 group) side by side.
module tb_clyde_sbox_layer_ctrl;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst, start, rnd_valid;

   logic       b0, d0, rr0, se0, iv0, we0;
   logic [2:0] ig0, og0;
   logic       b1, d1, rr1, se1, iv1, we1;
   logic [0:0] ig1, og1;
   logic [15:0] sc0, sc1;

   always #5 clk = ~clk;

   clyde_sbox_layer_ctrl u_dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(b0), .done(d0),
      .rnd_valid(rnd_valid), .rnd_ready(rr0), .sbox_en(se0),
      .in_grp(ig0), .in_vld(iv0), .out_grp(og0), .out_we(we0)
`ifdef CLYDE_SBOX_STALL_CNT_EN
     ,.stall_cnt(sc0)
`endif
   );

   clyde_sbox_layer_ctrl #(.NPAR(32)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .busy(b1), .done(d1),
      .rnd_valid(rnd_valid), .rnd_ready(rr1), .sbox_en(se1),
      .in_grp(ig1), .in_vld(iv1), .out_grp(og1), .out_we(we1)
`ifdef CLYDE_SBOX_STALL_CNT_EN
     ,.stall_cnt(sc1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: run progress counted in enabled cycles since start
   int mst[2];
   int me[2];
   int mstall[2];
   int ngrp[2] = '{8, 1};
   int q0[$];
   int q1[$];
   int we_cnt[2], done_cnt[2], first_done[2];

   logic [31:0] o_busy[2], o_done[2], o_se[2], o_rr[2], o_ig[2], o_iv[2], o_og[2], o_we[2], o_sc[2];

   task automatic sample();
      o_busy[0] = 32'(b0); o_done[0] = 32'(d0); o_se[0] = 32'(se0); o_rr[0] = 32'(rr0);
      o_ig[0] = 32'(ig0); o_iv[0] = 32'(iv0); o_og[0] = 32'(og0); o_we[0] = 32'(we0);
      o_busy[1] = 32'(b1); o_done[1] = 32'(d1); o_se[1] = 32'(se1); o_rr[1] = 32'(rr1);
      o_ig[1] = 32'(ig1); o_iv[1] = 32'(iv1); o_og[1] = 32'(og1); o_we[1] = 32'(we1);
      o_sc[0] = '0; o_sc[1] = '0;
`ifdef CLYDE_SBOX_STALL_CNT_EN
      o_sc[0] = 32'(sc0); o_sc[1] = 32'(sc1);
`endif
   endtask

   task automatic check_reset_outputs(input string p);
      sample();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_u%0d_busy", p, k), o_busy[k], 0);
         check($sformatf("%s_u%0d_done", p, k), o_done[k], 0);
         check($sformatf("%s_u%0d_sbox_en", p, k), o_se[k], 0);
         check($sformatf("%s_u%0d_in_vld", p, k), o_iv[k], 0);
         check($sformatf("%s_u%0d_out_we", p, k), o_we[k], 0);
         check($sformatf("%s_u%0d_in_grp", p, k), o_ig[k], 0);
`ifdef CLYDE_SBOX_STALL_CNT_EN
         check($sformatf("%s_u%0d_stall_cnt", p, k), o_sc[k], 0);
`endif
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mst[k] = 0; me[k] = 0; mstall[k] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_cycle(input int k, input int c, input bit st, input bit rv);
      int eb, ed, ese, eiv, ewe, g;
      string p;
      p = $sformatf("u%0d_c%0d", k, c);
      eb = 0; ed = 0; ese = 0; eiv = 0; ewe = 0; g = 0;
      if (mst[k] == 1) begin
         eb  = 1;
         eiv = (me[k] < ngrp[k]) ? 1 : 0;
         ese = rv ? 1 : 0;
         ewe = (rv && me[k] >= LAT && me[k] < ngrp[k] + LAT) ? 1 : 0;
      end else if (mst[k] == 2) begin
         ed = 1;
      end
      check({p, "_busy"}, o_busy[k], eb);
      check({p, "_done"}, o_done[k], ed);
      check({p, "_sbox_en"}, o_se[k], ese);
      check({p, "_rnd_ready"}, o_rr[k], ese);
      check({p, "_in_vld"}, o_iv[k], eiv);
      check({p, "_out_we"}, o_we[k], ewe);
      if (eiv == 1) check({p, "_in_grp"}, o_ig[k], me[k]);
      // Stimulus side: a committed group is expected back on out_grp later
      if (mst[k] == 1 && rv && me[k] < ngrp[k]) begin
         if (k == 0) q0.push_back(me[k]);
         else        q1.push_back(me[k]);
      end
      if (o_we[k] == 1) begin
         we_cnt[k]++;
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            check({p, "_sb_empty"}, 1, 0);
         end else begin
            g = (k == 0) ? q0.pop_front() : q1.pop_front();
            check({p, "_out_grp"}, o_og[k], g);
         end
      end
`ifdef CLYDE_SBOX_STALL_CNT_EN
      check({p, "_stall_cnt"}, o_sc[k], mstall[k]);
`endif
      if (o_done[k] == 1) begin
         done_cnt[k]++;
         if (first_done[k] < 0) first_done[k] = c;
      end
      case (mst[k])
         0: if (st) begin mst[k] = 1; me[k] = 0; mstall[k] = 0; end
         1: begin
            if (!rv) begin
               if (mstall[k] < 65535) mstall[k]++;
            end else if (me[k] == ngrp[k] + LAT - 1) begin
               mst[k] = 2;
            end else begin
               me[k]++;
            end
         end
         default: mst[k] = 0;
      endcase
   endtask

   typedef struct {
      int slo, shi, xs1, xs2, xs3, rc, ncyc;
      int dn0, dn1, dc0, dc1, we0, we1;
   } case_t;

   case_t cases[5] = '{
      '{-1, -1, -1, -1, -1, -1, 16, 13,  6, 1, 1,  8, 1},  // nominal run
      '{ 3,  5, -1, -1, -1, -1, 19, 16,  9, 1, 1,  8, 1},  // stall in FEED
      '{10, 11, -1, -1, -1, -1, 18, 15,  6, 1, 1,  8, 1},  // stall in DRAIN
      '{-1, -1,  4, 13, 14, -1, 32, 13,  6, 2, 2, 16, 2},  // start mid-run / on done / after done
      '{-1, -1,  9, -1, -1,  7, 25, 22,  6, 1, 2, 10, 2}   // reset mid-run then restart
   };

   initial begin
      bit st, rv;
      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1'b0;

      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 2; k++) begin
            we_cnt[k] = 0; done_cnt[k] = 0; first_done[k] = -1;
         end
         for (int c = 0; c < cases[n].ncyc; c++) begin
            @(posedge clk); #1;
            st = (c == 0 || c == cases[n].xs1 || c == cases[n].xs2 || c == cases[n].xs3);
            rv = !(c >= cases[n].slo && c <= cases[n].shi);
            start = st;
            rnd_valid = rv;
            if (c == cases[n].rc) begin
               rst = 1'b1;
               #1;
               check_reset_outputs($sformatf("t%0d_arst", n + 1));
               model_reset();
               #1;
               rst = 1'b0;
            end
            @(negedge clk);
            sample();
            check_cycle(0, c, st, rv);
            check_cycle(1, c, st, rv);
         end
         @(posedge clk); #1;
         start = 1'b0;
         rnd_valid = 1'b1;
         check($sformatf("t%0d_u0_first_done", n + 1), first_done[0], cases[n].dn0);
         check($sformatf("t%0d_u1_first_done", n + 1), first_done[1], cases[n].dn1);
         check($sformatf("t%0d_u0_done_cnt", n + 1), done_cnt[0], cases[n].dc0);
         check($sformatf("t%0d_u1_done_cnt", n + 1), done_cnt[1], cases[n].dc1);
         check($sformatf("t%0d_u0_we_cnt", n + 1), we_cnt[0], cases[n].we0);
         check($sformatf("t%0d_u1_we_cnt", n + 1), we_cnt[1], cases[n].we1);
         check($sformatf("t%0d_u0_sb_left", n + 1), q0.size(), 0);
         check($sformatf("t%0d_u1_sb_left", n + 1), q1.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
